// File: rtl/nrzi_pkg.sv
// NRZI decoder shared types: FSM state encoding, byte width, bit decode.
// Imported by nrzi_decoder.
package nrzi_pkg;

  localparam int BYTE_W = 8;
  localparam int BCNT_W = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_STUFF = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  // No line transition decodes as 1, a transition as 0.
  function automatic logic nrzi_bit(
    input logic lvl,
    input logic prev
  );
    return ~(lvl ^ prev);
  endfunction

endpackage

// File: rtl/nrzi_decoder.sv
// NRZI line decoder with bit-destuffing and byte assembly (LSB first).
// Ports: clk, rst (sync high), sof/eof strobes, din_valid/din line bit
//        in; dout/dout_valid byte out, stuff_err/frag_err pulses, busy.
module nrzi_decoder
  import nrzi_pkg::*;
#(
  parameter int   STUFF_LEN  = 6,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic              eof,
  input  logic              din_valid,
  input  logic              din,
  output logic [BYTE_W-1:0] dout,
  output logic              dout_valid,
  output logic              stuff_err,
  output logic              frag_err,
  output logic              busy
);

  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LEN);
  localparam logic [ONES_W-1:0] ONES_ONE = ONES_W'(1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTE_W - 1);
  localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);

  state_e              state;
  logic                prev_level;
  logic [BCNT_W-1:0]   bitcnt;
  logic [ONES_W-1:0]   ones;
  logic [BYTE_W-1:0]   sreg;

  // Values after an optional sof restart, before the bit is consumed.
  state_e              st_eff;
  logic                prev_eff;
  logic [BCNT_W-1:0]   bcnt_eff;
  logic [ONES_W-1:0]   ones_eff;
  logic [BYTE_W-1:0]   sreg_eff;

  state_e              st_n;
  logic                prev_n;
  logic [BCNT_W-1:0]   bcnt_n;
  logic [ONES_W-1:0]   ones_n;
  logic [BYTE_W-1:0]   sreg_n;
  logic [BYTE_W-1:0]   dout_n;
  logic                dv_n;
  logic                se_n;
  logic                fe_n;
  logic                dbit;
  logic                live;

  assign busy = (state == ST_DATA) || (state == ST_STUFF);

  // sof restarts the frame first so a coincident bit is decoded
  // against IDLE_LEVEL as bit 0 of the new frame.
  always_comb begin
    st_eff   = state;
    prev_eff = prev_level;
    bcnt_eff = bitcnt;
    ones_eff = ones;
    sreg_eff = sreg;
    if (sof) begin
      st_eff   = ST_DATA;
      prev_eff = IDLE_LEVEL;
      bcnt_eff = '0;
      ones_eff = '0;
      sreg_eff = '0;
    end
  end

  assign live = din_valid &&
                ((st_eff == ST_DATA) || (st_eff == ST_STUFF));
  assign dbit = nrzi_bit(din, prev_eff);

  always_comb begin
    st_n   = st_eff;
    prev_n = prev_eff;
    bcnt_n = bcnt_eff;
    ones_n = ones_eff;
    sreg_n = sreg_eff;
    dout_n = dout;
    dv_n   = 1'b0;
    se_n   = 1'b0;
    fe_n   = 1'b0;

    if (live) begin
      prev_n = din;
      unique case (1'b1)
        (st_eff == ST_DATA): begin
          sreg_n[bcnt_eff] = dbit;
          if (bcnt_eff == BCNT_LAST) begin
            dout_n = sreg_n;
            dv_n   = 1'b1;
            bcnt_n = '0;
          end else begin
            bcnt_n = bcnt_eff + BCNT_ONE;
          end
          // The ones run is kept across byte wraps.
          if (dbit) begin
            ones_n = ones_eff + ONES_ONE;
            if (ones_n == ONES_MAX) begin
              st_n = ST_STUFF;
            end
          end else begin
            ones_n = '0;
          end
        end
        (st_eff == ST_STUFF): begin
          ones_n = '0;
          if (dbit) begin
            se_n   = 1'b1;
            st_n   = ST_ERR;
            bcnt_n = '0;
            sreg_n = '0;
          end else begin
            st_n = ST_DATA;
          end
        end
        default: ;
      endcase
    end

    // eof is applied after the bit so a byte closing on it is clean.
    if (eof && !sof) begin
      unique case (1'b1)
        (st_n == ST_DATA),
        (st_n == ST_STUFF): begin
          fe_n   = (bcnt_n != '0);
          st_n   = ST_IDLE;
          bcnt_n = '0;
          ones_n = '0;
          sreg_n = '0;
        end
        (st_n == ST_ERR): st_n = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      prev_level <= IDLE_LEVEL;
      bitcnt     <= '0;
      ones       <= '0;
      sreg       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      stuff_err  <= 1'b0;
      frag_err   <= 1'b0;
    end else begin
      state      <= st_n;
      prev_level <= prev_n;
      bitcnt     <= bcnt_n;
      ones       <= ones_n;
      sreg       <= sreg_n;
      dout       <= dout_n;
      dout_valid <= dv_n;
      stuff_err  <= se_n;
      frag_err   <= fe_n;
    end
  end

endmodule
